// File: rtl/change_payout_sequencer.sv
// Greedy Rs.5/Rs.2/Rs.1 change payout sequencer with per-hopper req/ack timeout faults.
// Optional coin audit counters are enabled with `define COIN_AUDIT_EN.
module change_payout_sequencer #(
    parameter int AMT_W       = 4,
    parameter int ACK_TIMEOUT = 16,
    parameter int GAP_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic [2:0]       hopper_req,
    input  logic             hopper_ack,
    input  logic [2:0]       hopper_empty,
    output logic             done,
    output logic [AMT_W-1:0] paid,
    output logic [AMT_W-1:0] shortfall,
    output logic [2:0]       fault
`ifdef COIN_AUDIT_EN
    ,
    output logic [7:0]       audit_5,
    output logic [7:0]       audit_2,
    output logic [7:0]       audit_1
`endif
);

    localparam int TW = $clog2(ACK_TIMEOUT + GAP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, PICK, EJECT, GAP, DONE} state_t;

    state_t           state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [AMT_W-1:0] paid_q, paid_d;
    logic [AMT_W-1:0] short_q, short_d;
    logic [2:0]       fault_q, fault_d;
    logic [2:0]       coin_q, coin_d;
    logic [2:0]       req_q, req_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2:0]       pick_s;

    function automatic logic [AMT_W-1:0] coin_value(input logic [2:0] coin);
        case (coin)
            3'b100:  coin_value = AMT_W'(32'd5);
            3'b010:  coin_value = AMT_W'(32'd2);
            3'b001:  coin_value = AMT_W'(32'd1);
            default: coin_value = '0;
        endcase
    endfunction

    // Largest eligible coin for the remaining amount; zero means nothing can be paid.
    always_comb begin
        pick_s = 3'b000;
        if (rem_q == '0) begin
            pick_s = 3'b000;
        end else if (rem_q >= AMT_W'(32'd5) && !hopper_empty[2] && !fault_q[2]) begin
            pick_s = 3'b100;
        end else if (rem_q >= AMT_W'(32'd2) && !hopper_empty[1] && !fault_q[1]) begin
            pick_s = 3'b010;
        end else if (!hopper_empty[0] && !fault_q[0]) begin
            pick_s = 3'b001;
        end else begin
            pick_s = 3'b000;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        paid_d  = paid_q;
        short_d = short_q;
        fault_d = fault_q;
        coin_d  = coin_q;
        timer_d = timer_q;
        busy_d  = busy_q;
        req_d   = 3'b000;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = amount;
                    paid_d  = '0;
                    busy_d  = 1'b1;
                    state_d = PICK;
                end else begin
                    state_d = IDLE;
                end
            end
            PICK: begin
                if (pick_s != 3'b000) begin
                    coin_d  = pick_s;
                    req_d   = pick_s;
                    timer_d = '0;
                    state_d = EJECT;
                end else begin
                    short_d = rem_q;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            EJECT: begin
                // An ack on the final timeout cycle still counts as a successful eject.
                if (hopper_ack) begin
                    rem_d   = rem_q - coin_value(coin_q);
                    paid_d  = paid_q + coin_value(coin_q);
                    timer_d = '0;
                    state_d = GAP;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    fault_d = fault_q | coin_q;
                    state_d = PICK;
                end else begin
                    timer_d = timer_q + TW'(1);
                    req_d   = coin_q;
                end
            end
            GAP: begin
                if (timer_q == TW'(GAP_CYCLES - 1)) begin
                    state_d = PICK;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            paid_q  <= '0;
            short_q <= '0;
            fault_q <= 3'b000;
            coin_q  <= 3'b000;
            req_q   <= 3'b000;
            timer_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            paid_q  <= paid_d;
            short_q <= short_d;
            fault_q <= fault_d;
            coin_q  <= coin_d;
            req_q   <= req_d;
            timer_q <= timer_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign hopper_req = req_q;
    assign done       = done_q;
    assign paid       = paid_q;
    assign shortfall  = short_q;
    assign fault      = fault_q;

`ifdef COIN_AUDIT_EN
    logic [7:0] audit_5_q, audit_5_d;
    logic [7:0] audit_2_q, audit_2_d;
    logic [7:0] audit_1_q, audit_1_d;

    // Saturating per-denomination counts of acked coins.
    always_comb begin
        audit_5_d = audit_5_q;
        audit_2_d = audit_2_q;
        audit_1_d = audit_1_q;
        if (state_q == EJECT && hopper_ack) begin
            case (coin_q)
                3'b100:  audit_5_d = (audit_5_q == 8'd255) ? audit_5_q : audit_5_q + 8'd1;
                3'b010:  audit_2_d = (audit_2_q == 8'd255) ? audit_2_q : audit_2_q + 8'd1;
                3'b001:  audit_1_d = (audit_1_q == 8'd255) ? audit_1_q : audit_1_q + 8'd1;
                default: audit_1_d = audit_1_q;
            endcase
        end else begin
            audit_1_d = audit_1_q;
        end
    end

    // Audit counter registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            audit_5_q <= 8'd0;
            audit_2_q <= 8'd0;
            audit_1_q <= 8'd0;
        end else begin
            audit_5_q <= audit_5_d;
            audit_2_q <= audit_2_d;
            audit_1_q <= audit_1_d;
        end
    end

    assign audit_5 = audit_5_q;
    assign audit_2 = audit_2_q;
    assign audit_1 = audit_1_q;
`endif

endmodule

// File: tb/tb_change_payout_sequencer.sv
// Directed self-checking bench for change_payout_sequencer with an automatic hopper responder.
module tb_change_payout_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] amount = 4'd0;
    logic       busy;
    logic [2:0] hopper_req;
    logic       hopper_ack = 1'b0;
    logic [2:0] hopper_empty = 3'b000;
    logic       done;
    logic [3:0] paid;
    logic [3:0] shortfall;
    logic [2:0] fault;
`ifdef COIN_AUDIT_EN
    logic [7:0] audit_5, audit_2, audit_1;
`endif

    int n_assert = 0;
    int n_fail = 0;

    logic [2:0] no_ack_mask = 3'b000;
    int         ack_delay = 1;
    logic [2:0] req_log[$];
    int         len_log[$];
    logic [2:0] prev_req = 3'b000;
    logic       prev_busy = 1'b0;
    int         hold = 0;
    int         multi_hot = 0;
    int         busy_low = 0;
    int         cyc = 0;

    change_payout_sequencer #(.AMT_W(4), .ACK_TIMEOUT(16), .GAP_CYCLES(2)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .amount(amount),
        .busy(busy),
        .hopper_req(hopper_req),
        .hopper_ack(hopper_ack),
        .hopper_empty(hopper_empty),
        .done(done),
        .paid(paid),
        .shortfall(shortfall),
        .fault(fault)
`ifdef COIN_AUDIT_EN
        ,
        .audit_5(audit_5),
        .audit_2(audit_2),
        .audit_1(audit_1)
`endif
    );

    always #5 clk = ~clk;

    // Hopper model: logs request sequence / hold lengths and acks after ack_delay cycles.
    always @(posedge clk) begin
        #1;
        if (busy && !prev_busy) begin
            req_log.delete();
            len_log.delete();
        end
        prev_busy = busy;
        if ($countones(hopper_req) > 1) multi_hot++;
        if (hopper_req != 3'b000) begin
            if (hopper_req == prev_req) hold++;
            else begin
                req_log.push_back(hopper_req);
                hold = 1;
            end
        end else if (prev_req != 3'b000) begin
            len_log.push_back(hold);
        end
        prev_req = hopper_req;
        hopper_ack = (hopper_req != 3'b000) && ((hopper_req & no_ack_mask) == 3'b000)
                     && (hold == ack_delay);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a payout, optionally pulse a second start at cycle spur_at, wait for done.
    task automatic pay(input logic [3:0] amt, input int spur_at);
        @(negedge clk);
        amount = amt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        busy_low = 0;
        while (done !== 1'b1 && cyc < 400) begin
            if (busy !== 1'b1) busy_low++;
            if (cyc == spur_at) begin
                start = 1'b1;
                amount = 4'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("busy_at_done", {31'd0, busy}, 32'd1);
    endtask

    task automatic chk_after_done(input string tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req", {29'd0, hopper_req}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_paid", {28'd0, paid}, 32'd0);
        chk("rst_short", {28'd0, shortfall}, 32'd0);
        chk("rst_fault", {29'd0, fault}, 32'd0);
        reset = 1'b0;

        // 1: amount 3 -> Rs2, Rs1
        pay(4'd3, -1);
        chk("t1_cycles", cyc, 32'd10);
        chk("t1_paid", {28'd0, paid}, 32'd3);
        chk("t1_short", {28'd0, shortfall}, 32'd0);
        chk("t1_nreq", req_log.size(), 32'd2);
        chk("t1_req0", {29'd0, req_log[0]}, 32'h2);
        chk("t1_req1", {29'd0, req_log[1]}, 32'h1);
        chk("t1_fault", {29'd0, fault}, 32'd0);
        chk_after_done("t1");

        // 2: amount 8 -> Rs5, Rs2, Rs1; a start pulsed while busy is ignored
        pay(4'd8, 3);
        chk("t2_cycles", cyc, 32'd14);
        chk("t2_paid", {28'd0, paid}, 32'd8);
        chk("t2_short", {28'd0, shortfall}, 32'd0);
        chk("t2_busy_low", busy_low, 32'd0);
        chk("t2_nreq", req_log.size(), 32'd3);
        chk("t2_req0", {29'd0, req_log[0]}, 32'h4);
        chk("t2_req1", {29'd0, req_log[1]}, 32'h2);
        chk("t2_req2", {29'd0, req_log[2]}, 32'h1);
        chk_after_done("t2");
        repeat (3) @(negedge clk);
        chk("t2_spurious_idle", {31'd0, busy}, 32'd0);

        // 3: amount 7, Rs5 empty -> Rs2 x3, Rs1
        hopper_empty = 3'b100;
        pay(4'd7, -1);
        chk("t3_paid", {28'd0, paid}, 32'd7);
        chk("t3_short", {28'd0, shortfall}, 32'd0);
        chk("t3_nreq", req_log.size(), 32'd4);
        chk("t3_req2", {29'd0, req_log[2]}, 32'h2);
        chk("t3_req3", {29'd0, req_log[3]}, 32'h1);
        hopper_empty = 3'b000;

        // 4: Rs5 never acks -> held 16 cycles, fault, then Rs2, Rs2, Rs1
        no_ack_mask = 3'b100;
        pay(4'd5, -1);
        no_ack_mask = 3'b000;
        chk("t4_fault", {29'd0, fault}, 32'h4);
        chk("t4_hold", len_log.size() > 0 ? len_log[0] : 0, 32'd16);
        chk("t4_paid", {28'd0, paid}, 32'd5);
        chk("t4_nreq", req_log.size(), 32'd4);
        chk("t4_req0", {29'd0, req_log[0]}, 32'h4);
        chk("t4_req3", {29'd0, req_log[3]}, 32'h1);
        pay(4'd5, -1);
        chk("t4b_nreq", req_log.size(), 32'd3);
        chk("t4b_req0", {29'd0, req_log[0]}, 32'h2);
        chk("t4b_paid", {28'd0, paid}, 32'd5);

        // Ack on the last timeout cycle wins: no fault on Rs2
        ack_delay = 16;
        pay(4'd2, -1);
        ack_delay = 1;
        chk("edge_fault", {29'd0, fault}, 32'h4);
        chk("edge_paid", {28'd0, paid}, 32'd2);
        chk("edge_nreq", req_log.size(), 32'd1);
        chk("edge_hold", len_log.size() > 0 ? len_log[0] : 0, 32'd16);

        // 5: amount 4, Rs2 and Rs1 empty -> nothing paid
        hopper_empty = 3'b011;
        pay(4'd4, -1);
        chk("t5_cycles", cyc, 32'd2);
        chk("t5_paid", {28'd0, paid}, 32'd0);
        chk("t5_short", {28'd0, shortfall}, 32'd4);
        chk("t5_nreq", req_log.size(), 32'd0);
        hopper_empty = 3'b000;

        // 6: amount 9, reset during the second eject
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_fault_clr", {29'd0, fault}, 32'd0);
        amount = 4'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (hopper_req !== 3'b010 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("t6_second_eject", {29'd0, hopper_req}, 32'h2);
        chk("t6_paid_mid", {28'd0, paid}, 32'd5);
`ifdef COIN_AUDIT_EN
        chk("t6_audit5_mid", {24'd0, audit_5}, 32'd1);
`endif
        reset = 1'b1;
        @(negedge clk);
        chk("t6_req", {29'd0, hopper_req}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_paid", {28'd0, paid}, 32'd0);
        chk("t6_done", {31'd0, done}, 32'd0);
`ifdef COIN_AUDIT_EN
        chk("t6_audit5_rst", {24'd0, audit_5}, 32'd0);
`endif
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_idle_req", {29'd0, hopper_req}, 32'd0);
        chk("multi_hot", multi_hot, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
